// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit ALU command queue: opcodes, the queued
// command record and the default queue depth.
package alu8_pkg;

  localparam int DATA_W        = 8;
  localparam int DEPTH_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu8_cmd_queue_if.sv
// Command-in / result-out bundle of the ALU command queue; master is the
// producer/consumer side, slave is the queue.
interface alu8_cmd_queue_if #(
  parameter int DEPTH = alu8_pkg::DEPTH_DEFAULT
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_opcode;
  logic [7:0]             in_a;
  logic [7:0]             in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_result;
  logic                   out_zero;
  logic                   out_dz;
  logic                   out_illegal;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_dz, out_illegal, count
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_dz, out_illegal, count
  );
endinterface

// File: rtl/alu8_cmd_queue_alu8.sv
// Combinational 8-bit ALU: add/sub/mul modulo 256, unsigned floor divide.
// Divide by zero yields all-ones and illegal opcodes yield zero.
module alu8
  import alu8_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_DIV:  y = (b == '0) ? '1 : a / b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu8_cmd_queue.sv
// Command FIFO feeding a combinational ALU from its head; results land in a
// single output register with valid/ready back-pressure.
module alu8_cmd_queue
  import alu8_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  alu8_cmd_queue_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t              mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              ready;
  logic              push;
  logic              pop;
  cmd_t              in_cmd;

  cmd_t              head_p0;
  logic [DATA_W-1:0] alu_y_p0;
  logic              dz_p0;
  logic              ill_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] res_p1;
  logic              zero_p1;
  logic              dz_p1;
  logic              ill_p1;

  // in_ready depends only on the registered count
  assign ready  = (cnt < CW'(DEPTH));
  assign push   = bus.in_valid && ready;
  assign pop    = (cnt != '0) && (!vld_p1 || bus.out_ready);
  assign in_cmd = '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // ---- stage p0: queue head through ALU, flags decoded alongside ----
  assign head_p0 = mem[rd_ptr];
  assign dz_p0   = (head_p0.opcode == OP_DIV) && (head_p0.b == '0);
  assign ill_p0  = head_p0.opcode[2];

  alu8 u_alu (
    .op (head_p0.opcode),
    .a  (head_p0.a),
    .b  (head_p0.b),
    .y  (alu_y_p0)
  );

  // ---- stage p1: result register, loaded only on pop ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      dz_p1   <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      res_p1  <= alu_y_p0;
      zero_p1 <= (alu_y_p0 == '0);
      dz_p1   <= dz_p0;
      ill_p1  <= ill_p0;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.count       = cnt;
  assign bus.out_valid   = vld_p1;
  assign bus.out_result  = res_p1;
  assign bus.out_zero    = zero_p1;
  assign bus.out_dz      = dz_p1;
  assign bus.out_illegal = ill_p1;

endmodule

// File: tb/tb_alu8_cmd_queue.sv
// Directed bench for alu8_cmd_queue: queue-level reference model checked
// every cycle, plus literal checks on the delivered result stream.
module tb_alu8_cmd_queue;
  import alu8_pkg::*;

  localparam int DEPTH = 4;

  typedef struct { int op; int a; int b; } mcmd_t;
  typedef struct { int res; int z; int dz; int ill; } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu8_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  alu8_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic rec_t model_op(input int op, input int a, input int b);
    rec_t r;
    r.dz  = 0;
    r.ill = 0;
    r.res = 0;
    if (op >= 4) r.ill = 1;
    else case (op)
      0: r.res = (a + b) % 256;
      1: r.res = (a - b + 256) % 256;
      2: r.res = (a * b) % 256;
      default: begin
        if (b == 0) begin r.res = 255; r.dz = 1; end
        else r.res = a / b;
      end
    endcase
    r.z = (r.res == 0) ? 1 : 0;
    return r;
  endfunction

  // Reference model: a plain queue plus one held output record
  mcmd_t q[$];
  int    mvalid = 0;
  rec_t  mout = '{0, 0, 0, 0};
  rec_t  got[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mvalid <= 0;
      mout   <= '{0, 0, 0, 0};
    end else begin
      int    sz;
      mcmd_t c;
      sz = q.size();
      if (sz > 0 && (mvalid == 0 || bus.out_ready)) begin
        c = q.pop_front();
        mout   <= model_op(c.op, c.a, c.b);
        mvalid <= 1;
      end else if (bus.out_ready) begin
        mvalid <= 0;
      end
      if (bus.in_valid && sz < DEPTH)
        q.push_back('{int'(bus.in_opcode), int'(bus.in_a), int'(bus.in_b)});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",    int'(bus.in_ready),    (q.size() < DEPTH) ? 1 : 0);
      check("count",       int'(bus.count),       q.size());
      check("out_valid",   int'(bus.out_valid),   mvalid);
      check("out_result",  int'(bus.out_result),  mout.res);
      check("out_zero",    int'(bus.out_zero),    mout.z);
      check("out_dz",      int'(bus.out_dz),      mout.dz);
      check("out_illegal", int'(bus.out_illegal), mout.ill);
      if (bus.out_valid && bus.out_ready)
        got.push_back('{int'(bus.out_result), int'(bus.out_zero), int'(bus.out_dz), int'(bus.out_illegal)});
    end
  end

  function automatic rec_t got_at(input int i);
    rec_t none;
    none = '{-1, -1, -1, -1};
    if (i < 0 || i >= got.size()) return none;
    return got[i];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    do begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got no accept after %0d cycles, expected accept", n);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    rec_t r;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Model pinned to hand-computed values
    check("pin_sub", model_op(1, 8'h03, 8'h05).res, 8'hFE);
    check("pin_mul", model_op(2, 8'h10, 8'h11).res, 8'h10);
    check("pin_div", model_op(3, 8'h64, 8'h07).res, 8'h0E);
    check("pin_dz",  model_op(3, 8'h64, 8'h00).dz,  1);

    tick(3);
    check("rst_out_valid", int'(bus.out_valid),  0);
    check("rst_count",     int'(bus.count),      0);
    check("rst_result",    int'(bus.out_result), 0);
    check("rst_flags",     int'({bus.out_zero, bus.out_dz, bus.out_illegal}), 0);
    rst_n = 1'b1;

    // Add: result visible one edge after the push edge
    push(OP_ADD, 8'h05, 8'h03);
    idle();
    check("lat_not_yet", int'(bus.out_valid), 0);
    tick(1);
    check("lat_valid",  int'(bus.out_valid),  1);
    check("lat_result", int'(bus.out_result), 8'h08);
    check("lat_flags",  int'({bus.out_zero, bus.out_dz, bus.out_illegal}), 0);
    tick(2);

    // Sub then mul, back to back
    base = got.size();
    push(OP_SUB, 8'h03, 8'h05);
    push(OP_MUL, 8'h10, 8'h11);
    idle();
    tick(4);
    check("sub_res", got_at(base).res,     8'hFE);
    check("mul_res", got_at(base + 1).res, 8'h10);

    // Divide by zero then ordinary divide
    base = got.size();
    push(OP_DIV, 8'h64, 8'h00);
    push(OP_DIV, 8'h64, 8'h07);
    idle();
    tick(4);
    r = got_at(base);
    check("dz_res",  r.res, 8'hFF);
    check("dz_flag", r.dz,  1);
    r = got_at(base + 1);
    check("div_res",  r.res, 8'h0E);
    check("div_flag", r.dz,  0);

    // Fill with consumer stalled, then drain
    base = got.size();
    bus.out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push(OP_ADD, 8'(i), 8'h01);
    bus.in_opcode = OP_ADD;
    bus.in_a      = 8'h50;
    bus.in_b      = 8'h00;
    tick(3);
    check("full_ready",  int'(bus.in_ready),   0);
    check("full_count",  int'(bus.count),      DEPTH);
    check("full_valid",  int'(bus.out_valid),  1);
    check("full_stable", int'(bus.out_result), 1);
    idle();
    bus.out_ready = 1'b1;
    tick(DEPTH + 4);
    check("drain_n", got.size() - base, DEPTH + 1);
    for (int i = 0; i <= DEPTH; i++) check("drain_res", got_at(base + i).res, i + 1);

    // Illegal opcode
    base = got.size();
    push(3'b101, 8'hFF, 8'h01);
    idle();
    tick(3);
    r = got_at(base);
    check("ill_res",  r.res, 8'h00);
    check("ill_zero", r.z,   1);
    check("ill_flag", r.ill, 1);

    // Asynchronous reset with work pending
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(OP_MUL, 8'(i + 2), 8'h03);
    idle();
    check("pre_rst_count", int'(bus.count),     3);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_count", int'(bus.count),     0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = got.size();
    push(OP_ADD, 8'h07, 8'h07);
    idle();
    tick(5);
    check("post_rst_n",   got.size() - base,   1);
    check("post_rst_res", got_at(base).res,    8'h0E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu8_cmd_queue.md
ALU8_CMD_QUEUE -- requirements
Module: alu8_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning command-queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  queue can accept a command.
REQ-006 in_opcode  input  3  operation: 000 add, 001 sub, 010 mul, 011 div, 1xx illegal.
REQ-007 in_a  input  8  operand A.
REQ-008 in_b  input  8  operand B.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  8  computed result.
REQ-012 out_zero  output  1  out_result == 0.
REQ-013 out_dz  output  1  result came from a divide with B == 0.
REQ-014 out_illegal  output  1  result came from an illegal opcode.
REQ-015 count  output  log2(DEPTH)+1  commands queued, excluding the result register.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready; {opcode,a,b} written at the write pointer, pointer increments modulo DEPTH.
REQ-017 in_ready SHALL be (count < DEPTH), registered-state only, with no combinational path from out_ready or in_valid.
REQ-018 Head entry SHALL drive the ALU combinationally; the result SHALL be loaded into the output register only on a pop.
REQ-019 Pop SHALL occur when count > 0 and (!out_valid || out_ready); the read pointer increments modulo DEPTH, out_valid is set, and out_result and flags are loaded.
REQ-020 When out_valid && out_ready with count == 0, out_valid SHALL clear; out_result and flags SHALL hold their last values.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push into the slot freed by the same-edge pop SHALL NOT occur (in_ready reflects pre-edge count).
REQ-022 Latency: command pushed at edge N into an empty queue with empty output SHALL have out_valid high after edge N+1.
REQ-023 Throughput: with out_ready held high and in_valid continuous, one result per cycle SHALL be sustained.
REQ-024 Arithmetic: add and sub modulo 256; mul SHALL return the low 8 bits of A*B; div SHALL return floor(A/B), unsigned.
REQ-025 Div with B == 0 SHALL return 8'hFF with out_dz = 1; all other ops SHALL give out_dz = 0.
REQ-026 Opcode 1xx SHALL return 8'h00 with out_illegal = 1 and SHALL still be queued and popped in order.
REQ-027 Results SHALL emerge in push order; no drop or duplication; out_result and flags SHALL remain stable while out_valid && !out_ready.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; full (count == DEPTH) and empty (count == 0) SHALL be distinguished by count, not pointer equality.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force count = 0, both pointers = 0, out_valid = 0, out_result = 0, out_zero = 0, out_dz = 0, out_illegal = 0.
REQ-030 Reset mid-operation SHALL discard all queued commands and any pending result; queue storage itself need not be cleared.
REQ-031 First push SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package alu8_pkg SHALL hold opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, the command struct typedef {opcode,a,b}, and DEPTH_DEFAULT.
REQ-033 The arithmetic SHALL be a single instantiated sub-module, the team's existing combinational ALU8, fed from the queue head; the div-zero and illegal flags are decoded beside it in this block.

Verification
REQ-034 Reset, push add 8'h05 + 8'h03, out_ready = 1 -> out_valid one cycle after push edge, out_result = 8'h08, all flags 0.
REQ-035 Push sub 8'h03 - 8'h05, then mul 8'h10 * 8'h11 -> 8'hFE, then 8'h10, in order.
REQ-036 Push div 8'h64 / 8'h00 then div 8'h64 / 8'h07 -> 8'hFF with out_dz = 1, then 8'h0E with out_dz = 0.
REQ-037 out_ready = 0, push DEPTH+1 commands with in_valid held -> in_ready low after DEPTH pushes plus one into the output register, count = DEPTH, output stable; release out_ready -> all DEPTH+1 results in order.
REQ-038 Opcode 3'b101 with A = 8'hFF, B = 8'h01 -> out_result = 8'h00, out_zero = 1, out_illegal = 1.
REQ-039 With 3 queued and out_valid high, pulse rst_n low mid-cycle -> out_valid and count 0 immediately; the next push yields only its own result.
